// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: instruction-fetch sequencer feeding decode from a prefetch FIFO.
// Ports: clk/reset_n (sync, active-low); imem_a/imem_rd combinational imem port;
//   redirect_valid/redirect_pc restart fetch; inst_valid/inst_ready/inst_out/inst_pc
//   decode handshake; misalign_err sticky error on a misaligned redirect.
// Optional macro FETCH_PERF_CNT_EN adds fetch_cnt (pushes) and stall_cnt (full-FIFO stalls).
module imem_fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [31:0] imem_a,
  input  logic [31:0] imem_rd,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  output logic        misalign_err
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] stall_cnt
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  state_t             state_q, state_d;
  logic [31:0]        fetch_pc;
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [31:0]        mem_inst [FIFO_DEPTH];
  logic [31:0]        mem_pc   [FIFO_DEPTH];
  logic [31:0]        held_inst, held_pc;

  logic full, push, pop, flush, aligned;

  assign imem_a     = fetch_pc;
  assign inst_valid = (count != '0);
  assign full       = (count == CNT_W'(FIFO_DEPTH));
  assign pop        = inst_valid && inst_ready;
  // Redirects are only honoured outside HALT; they discard the whole buffer.
  assign flush      = redirect_valid && (state_q != HALT);
  assign aligned    = (redirect_pc[1:0] == 2'b00);
  assign push       = (state_q == RUN) && !redirect_valid && (!full || pop);

  // When empty, present the last head seen so the outputs never float to stale slots.
  assign inst_out = inst_valid ? mem_inst[rd_ptr] : held_inst;
  assign inst_pc  = inst_valid ? mem_pc[rd_ptr]   : held_pc;

  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT: state_d = (redirect_valid && !aligned) ? HALT : RUN;
      RUN:  if (redirect_valid && !aligned) state_d = HALT;
      HALT: state_d = HALT;
      default: state_d = HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= BOOT;
      fetch_pc     <= RESET_PC;
      misalign_err <= 1'b0;
    end else begin
      state_q <= state_d;
      if (flush) begin
        if (aligned) fetch_pc <= redirect_pc;
        else         misalign_err <= 1'b1;
      end else if (push) begin
        fetch_pc <= fetch_pc + 32'd4;
      end
    end
  end

  // Storage needs no reset: it is only observed while its slot is occupied.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_inst[wr_ptr] <= imem_rd;
      mem_pc[wr_ptr]   <= fetch_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      held_inst <= '0;
      held_pc   <= '0;
    end else begin
      if (inst_valid) begin
        held_inst <= mem_inst[rd_ptr];
        held_pc   <= mem_pc[rd_ptr];
      end
      if (flush) begin
        // Drop everything in place; a same-cycle pop is discarded with it.
        wr_ptr <= rd_ptr;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        count <= count + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (push) fetch_cnt <= fetch_cnt + 32'd1;
      if ((state_q == RUN) && full && !pop) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
module tb_imem_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] imem_a;
  logic [31:0] imem_rd;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic        misalign_err;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  // imem model: word i lives at byte address 4*i and holds 0x1000_0000 + i.
  assign imem_rd = 32'h1000_0000 + (imem_a >> 2);

  imem_fetch_ctrl #(.RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .imem_a         (imem_a),
    .imem_rd        (imem_rd),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_out       (inst_out),
    .inst_pc        (inst_pc),
    .misalign_err   (misalign_err)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_cnt      (fetch_cnt),
    .stall_cnt      (stall_cnt)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the DUT in reset for two edges; caller releases reset_n (cycle c0 = BOOT).
  task automatic hold_reset();
    reset_n        = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    inst_ready     = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    hold_reset();
    total_cnt++; if (inst_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", inst_valid); else pass_cnt++;
    total_cnt++; if (inst_out !== 32'h0) $display("FAIL reset_out: got %h want 0", inst_out); else pass_cnt++;
    total_cnt++; if (inst_pc !== 32'h0) $display("FAIL reset_pc: got %h want 0", inst_pc); else pass_cnt++;
    total_cnt++; if (imem_a !== 32'h0) $display("FAIL reset_imem_a: got %h want 0", imem_a); else pass_cnt++;
    total_cnt++; if (misalign_err !== 1'b0) $display("FAIL reset_err: got %b want 0", misalign_err); else pass_cnt++;
    reset_n = 1'b1;
  endtask

  task automatic test_streaming();
    logic [31:0] exp_pc [5] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
    logic [31:0] exp_in [5] = '{32'h1000_0000, 32'h1000_0001, 32'h1000_0002, 32'h1000_0003, 32'h1000_0004};
    hold_reset();
    reset_n = 1'b1;
    inst_ready = 1'b1;
    total_cnt++; if (inst_valid !== 1'b0) $display("FAIL stream_boot_valid: got %b want 0", inst_valid); else pass_cnt++;
    tick();
    total_cnt++; if (inst_valid !== 1'b0) $display("FAIL stream_c1_valid: got %b want 0", inst_valid); else pass_cnt++;
    tick();
    for (int k = 0; k < 5; k++) begin
      total_cnt++;
      if (inst_valid !== 1'b1 || inst_pc !== exp_pc[k] || inst_out !== exp_in[k])
        $display("FAIL stream_%0d: got v=%b pc=%h out=%h want v=1 pc=%h out=%h",
                 k, inst_valid, inst_pc, inst_out, exp_pc[k], exp_in[k]);
      else pass_cnt++;
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_pc [3] = '{32'h0, 32'h4, 32'h8};
    hold_reset();
    reset_n = 1'b1;
    tick();
    tick();
    // c2 .. c6: head stays at PC 0 while the FIFO fills and stalls.
    for (int c = 2; c <= 6; c++) begin
      total_cnt++;
      if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst_out !== 32'h1000_0000)
        $display("FAIL bp_hold_c%0d: got v=%b pc=%h out=%h want v=1 pc=0 out=10000000",
                 c, inst_valid, inst_pc, inst_out);
      else pass_cnt++;
      if (c < 6) tick();
    end
    total_cnt++; if (imem_a !== 32'h8) $display("FAIL bp_imem_a: got %h want 8", imem_a); else pass_cnt++;
    tick();
    inst_ready = 1'b1;
`ifdef FETCH_PERF_CNT_EN
    total_cnt++; if (stall_cnt !== 32'd4) $display("FAIL bp_stall_cnt: got %0d want 4", stall_cnt); else pass_cnt++;
    total_cnt++; if (fetch_cnt !== 32'd2) $display("FAIL bp_fetch_cnt_fill: got %0d want 2", fetch_cnt); else pass_cnt++;
`endif
    for (int k = 0; k < 3; k++) begin
      total_cnt++;
      if (inst_valid !== 1'b1 || inst_pc !== exp_pc[k])
        $display("FAIL bp_resume_%0d: got v=%b pc=%h want v=1 pc=%h", k, inst_valid, inst_pc, exp_pc[k]);
      else pass_cnt++;
      tick();
    end
    // c10: flush two buffered entries (PC C, 10) with a redirect.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    tick();
    redirect_valid = 1'b0;
`ifdef FETCH_PERF_CNT_EN
    total_cnt++; if (fetch_cnt !== 32'd5) $display("FAIL bp_fetch_cnt: got %0d want 5", fetch_cnt); else pass_cnt++;
    total_cnt++; if (stall_cnt !== 32'd4) $display("FAIL bp_stall_cnt_after: got %0d want 4", stall_cnt); else pass_cnt++;
`endif
    total_cnt++; if (inst_valid !== 1'b0) $display("FAIL bp_flush_valid: got %b want 0", inst_valid); else pass_cnt++;
  endtask

  task automatic test_redirect();
    hold_reset();
    reset_n = 1'b1;
    tick();
    tick();
    tick();
    // c3: FIFO holds PC 0 and 4; the pop offered here must be discarded.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    inst_ready     = 1'b1;
    tick();
    redirect_valid = 1'b0;
    total_cnt++; if (inst_valid !== 1'b0) $display("FAIL redir_flush_valid: got %b want 0", inst_valid); else pass_cnt++;
    tick();
    total_cnt++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h40 || inst_out !== 32'h1000_0010)
      $display("FAIL redir_first: got v=%b pc=%h out=%h want v=1 pc=40 out=10000010", inst_valid, inst_pc, inst_out);
    else pass_cnt++;
    tick();
    total_cnt++; if (inst_pc !== 32'h44) $display("FAIL redir_second: got pc=%h want 44", inst_pc); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    tick();
    redirect_pc    = 32'h200;
    total_cnt++; if (inst_valid !== 1'b0) $display("FAIL b2b_mid_valid: got %b want 0", inst_valid); else pass_cnt++;
    tick();
    redirect_valid = 1'b0;
    total_cnt++; if (imem_a !== 32'h200) $display("FAIL b2b_imem_a: got %h want 200", imem_a); else pass_cnt++;
    tick();
    total_cnt++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h200 || inst_out !== 32'h1000_0080)
      $display("FAIL b2b_head: got v=%b pc=%h out=%h want v=1 pc=200 out=10000080", inst_valid, inst_pc, inst_out);
    else pass_cnt++;
  endtask

  task automatic test_boot_redirect();
    hold_reset();
    reset_n        = 1'b1;
    inst_ready     = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h80;
    tick();
    redirect_valid = 1'b0;
    total_cnt++;
    if (inst_valid !== 1'b0 || imem_a !== 32'h80)
      $display("FAIL boot_redir_c1: got v=%b imem_a=%h want v=0 imem_a=80", inst_valid, imem_a);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h80 || inst_out !== 32'h1000_0020)
      $display("FAIL boot_redir_head: got v=%b pc=%h out=%h want v=1 pc=80 out=10000020", inst_valid, inst_pc, inst_out);
    else pass_cnt++;
  endtask

  task automatic test_misalign();
    hold_reset();
    reset_n    = 1'b1;
    inst_ready = 1'b1;
    tick();
    tick();
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h42;
    tick();
    // Aligned redirect while halted must be ignored.
    redirect_pc    = 32'h40;
    total_cnt++;
    if (misalign_err !== 1'b1 || inst_valid !== 1'b0 || imem_a !== 32'h8)
      $display("FAIL mis_enter: got err=%b v=%b imem_a=%h want err=1 v=0 imem_a=8", misalign_err, inst_valid, imem_a);
    else pass_cnt++;
    tick();
    redirect_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      total_cnt++;
      if (misalign_err !== 1'b1 || inst_valid !== 1'b0 || imem_a !== 32'h8)
        $display("FAIL mis_halt_%0d: got err=%b v=%b imem_a=%h want err=1 v=0 imem_a=8",
                 c, misalign_err, inst_valid, imem_a);
      else pass_cnt++;
      tick();
    end
    hold_reset();
    total_cnt++; if (misalign_err !== 1'b0) $display("FAIL mis_reset_clear: got %b want 0", misalign_err); else pass_cnt++;
    reset_n = 1'b1;
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc [3] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    logic [31:0] exp_in [3] = '{32'h4FFF_FFFE, 32'h4FFF_FFFF, 32'h1000_0000};
    hold_reset();
    reset_n    = 1'b1;
    inst_ready = 1'b1;
    tick();
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF8;
    tick();
    redirect_valid = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      total_cnt++;
      if (inst_valid !== 1'b1 || inst_pc !== exp_pc[k] || inst_out !== exp_in[k])
        $display("FAIL wrap_%0d: got v=%b pc=%h out=%h want v=1 pc=%h out=%h",
                 k, inst_valid, inst_pc, inst_out, exp_pc[k], exp_in[k]);
      else pass_cnt++;
      tick();
    end
  endtask

  initial begin
    reset_n        = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    inst_ready     = 1'b0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_redirect();
    test_back_to_back();
    test_boot_redirect();
    test_misalign();
    test_wrap();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/imem_fetch_ctrl.md
Name: imem_fetch_ctrl

Overview:
Instruction-fetch sequencer in front of the combinational-read instruction memory (imem: 32-bit byte address in, 32-bit word out, same cycle). It owns the fetch PC and steps it by 4. It buffers fetched words with their PCs in a small FIFO and hands them to the decode stage over a valid/ready handshake. Redirects from branches and jumps flush the buffer and restart fetch.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset; must be word-aligned.
FIFO_DEPTH, 2, prefetch entries; power of 2, minimum 2.

Ports:
clk  input  1  clock; all state updates on rising edge
reset_n  input  1  synchronous, active-low reset
imem_a  output  32  address to imem; always equals fetch_pc
imem_rd  input  32  imem read data for imem_a, valid in the same cycle
redirect_valid  input  1  flush and restart fetch at redirect_pc
redirect_pc  input  32  new fetch address
inst_valid  output  1  FIFO head holds a valid instruction
inst_ready  input  1  consumer accepts the head this cycle
inst_out  output  32  instruction word at the FIFO head
inst_pc  output  32  PC of inst_out
misalign_err  output  1  sticky; a misaligned redirect was received

Behaviour:
- Reset (reset_n=0 at a clk edge): state=BOOT, fetch_pc=RESET_PC, FIFO empty, misalign_err=0. Outputs: inst_valid=0, inst_out=0, inst_pc=0, imem_a=RESET_PC.
- States:
  - BOOT: lasts one cycle with no fetch, then moves to RUN.
  - RUN: normal fetching.
  - HALT: no fetch, FIFO frozen; left only by reset.
- push = (state==RUN) && !redirect_valid && (!full || pop).
- pop = inst_valid && inst_ready.
- On push: write {fetch_pc, imem_rd} to the tail; fetch_pc <= fetch_pc+4.
  - Wraps mod 2^32: 32'hFFFF_FFFC goes to 32'h0.
- Latency: a word pushed at edge N appears on inst_out/inst_pc after edge N, so inst_valid can first assert one cycle after leaving BOOT.
- Full FIFO with simultaneous pop: push and pop happen in the same cycle, so sustained throughput is 1 instruction/cycle.
- Full FIFO without pop: no push; fetch_pc holds.
- Empty FIFO: inst_valid=0. inst_out/inst_pc hold their last values (don't-care, but must not be X after reset).
- inst_out and inst_pc must stay stable while inst_valid=1 && inst_ready=0.
- Redirect (state RUN or BOOT, redirect_valid=1), highest priority:
  - FIFO flushed. Any pop this cycle is discarded, and inst_valid is 0 on the next cycle.
  - No push this cycle.
  - If redirect_pc[1:0]==2'b00: fetch_pc <= redirect_pc; state goes to or stays in RUN.
  - Otherwise: fetch_pc unchanged, misalign_err <= 1, state <= HALT.
- Redirect during BOOT cancels BOOT, so fetch starts the next cycle from redirect_pc.
- Redirects are ignored in HALT.
- Back-to-back redirects: each one wins; the last one determines fetch_pc.
- Reset asserted mid-operation overrides everything in the same edge.
- Occupancy counter width is clog2(FIFO_DEPTH)+1. Read and write pointers wrap modulo FIFO_DEPTH.

Optional Feature:
Macro FETCH_PERF_CNT_EN.
- When defined, two extra output ports are added:
  - fetch_cnt[31:0]: increments on every push.
  - stall_cnt[31:0]: increments every RUN cycle where the FIFO is full and there is no pop.
  - Both reset to 0 under reset_n=0 and wrap at 2^32.
- When undefined, the ports and logic are absent and the remaining behaviour is identical.

Test Plan:
1. Reset, then streaming. imem word i = 32'h1000_0000+i. Hold reset_n=0 for 2 cycles, then inst_ready=1. Required: inst_valid first high 2 cycles after release; inst_pc = 0,4,8,C,10 on consecutive cycles; inst_out = 1000_0000 … 1000_0004.
2. Backpressure. inst_ready=0 for 6 cycles after streaming starts. Required: FIFO fills to 2; inst_pc holds at 0 and inst_out stays stable; fetch_pc/imem_a holds at 8. Then raise inst_ready: outputs resume 0,4,8 with no gap or duplicate.
3. Aligned redirect. redirect_valid=1 with redirect_pc=32'h40 while FIFO holds 2 entries. Required: next cycle inst_valid=0; the following cycle inst_pc=40, inst_out=1000_0010; no stale PC 4/8 is ever emitted.
4. Misaligned redirect. redirect_pc=32'h42. Required: misalign_err=1 next cycle and stays 1; inst_valid=0 thereafter; imem_a frozen; a later aligned redirect is ignored; reset clears the error.
5. Wrap-around. Redirect to 32'hFFFF_FFF8. Required: inst_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
6. FETCH_PERF_CNT_EN defined, scenario 2 repeated. Required: stall_cnt = 4 (6 stalled cycles minus 2 fill cycles); fetch_cnt equals the count of accepted plus flushed entries.
